// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose: MEM-stage load/store unit for a simple in-order pipeline.
// Aligned loads and stores run a single-outstanding data-memory transaction.
// While that transaction is open the unit holds the MEM pipeline register
// through stall. Instructions with no memory operation, and misaligned
// accesses, retire on the next cycle without using the bus. All writeback
// and exception outputs are registered. A wait counter turns a missing
// dmem_ack into a bus error.
//
// FSM: IDLE -> WAIT (transaction open) -> DONE (one cycle) -> IDLE.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   in_valid           MEM pipeline register holds a live instruction
//   in_mem_read/write  load / store request
//   in_funct3          access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   in_addr            effective address
//   in_wdata           store data
//   in_alu             non-memory result
//   in_rd              destination register
//   in_reg_write       writeback enable
//   flush              kill the current instruction
//   dmem_req/we/addr/wstrb/wdata   data-memory request (word aligned)
//   dmem_ack, dmem_rdata           data-memory response
//   stall              hold request to the hazard unit
//   wb_valid/reg_write/rd/data     registered writeback
//   misalign_exc, bus_err          registered single-cycle exception pulses
// ----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [31:0] in_alu,
   input  logic [4:0]  in_rd,
   input  logic        in_reg_write,
   input  logic        flush,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign_exc,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        flush_pend_q, flush_pend_d;

   // Request fields captured when the transaction opens. They stay fixed
   // until the ack, whatever happens on the pipeline inputs.
   logic [31:0] addr_q, addr_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        we_q, we_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;
   logic        reg_write_q, reg_write_d;

   logic        wb_valid_q, wb_valid_d;
   logic        wb_reg_write_q, wb_reg_write_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic        mem_op;
   logic        misaligned;
   logic [3:0]  strb_new;
   logic [31:0] wdata_new;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [7:0]  cnt_inc;
   logic        kill;

   assign mem_op     = in_mem_read | in_mem_write;
   assign misaligned = ((in_funct3[1:0] == 2'b01) &&  in_addr[0]) ||
                       ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
   assign cnt_inc    = cnt_q + 8'd1;
   // A flush seen on any WAIT cycle, including the ack cycle, kills the result.
   assign kill       = flush_pend_q | flush;

   // Store lane strobes and lane-replicated store data.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      strb_new  = 4'b1111;
      wdata_new = in_wdata;
      case (in_funct3[1:0])
         2'b00: begin
            strb_new  = 4'b0001 << in_addr[1:0];
            wdata_new = {4{in_wdata[7:0]}};
         end
         2'b01: begin
            strb_new  = 4'b0011 << in_addr[1:0];
            wdata_new = {2{in_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Load extraction from the captured address and size.
   always_comb begin
      ld_byte = dmem_rdata[7:0];
      case (addr_q[1:0])
         2'b01:   ld_byte = dmem_rdata[15:8];
         2'b10:   ld_byte = dmem_rdata[23:16];
         2'b11:   ld_byte = dmem_rdata[31:24];
         default: ;
      endcase
      ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (funct3_q[1:0])
         2'b00:   ld_data = funct3_q[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = funct3_q[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_data = dmem_rdata;
      endcase
   end

   // Next-state and output logic.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      flush_pend_d   = flush_pend_q;
      addr_d         = addr_q;
      funct3_d       = funct3_q;
      we_d           = we_q;
      wstrb_d        = wstrb_q;
      wdata_d        = wdata_q;
      rd_d           = rd_q;
      reg_write_d    = reg_write_q;
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
      wb_rd_d        = wb_rd_q;
      wb_data_d      = wb_data_q;
      misalign_d     = 1'b0;
      bus_err_d      = 1'b0;
      stall          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid && !flush) begin
               if (!mem_op) begin
                  wb_valid_d     = 1'b1;
                  wb_reg_write_d = in_reg_write;
                  wb_rd_d        = in_rd;
                  wb_data_d      = in_alu;
               end else if (misaligned) begin
                  // The faulting address is reported on wb_data.
                  wb_valid_d = 1'b1;
                  misalign_d = 1'b1;
                  wb_rd_d    = in_rd;
                  wb_data_d  = in_addr;
               end else begin
                  stall        = 1'b1;
                  state_d      = S_WAIT;
                  cnt_d        = 8'd0;
                  flush_pend_d = 1'b0;
                  addr_d       = in_addr;
                  funct3_d     = in_funct3;
                  we_d         = in_mem_write;
                  wstrb_d      = in_mem_write ? strb_new : 4'b0000;
                  wdata_d      = wdata_new;
                  rd_d         = in_rd;
                  reg_write_d  = in_reg_write;
               end
            end
         end

         S_WAIT: begin
            stall        = 1'b1;
            flush_pend_d = kill;
            if (dmem_ack) begin
               // An ack wins over a timeout on the same cycle.
               state_d        = S_DONE;
               wb_valid_d     = !kill;
               wb_reg_write_d = !kill && !we_q && reg_write_q;
               wb_rd_d        = rd_q;
               wb_data_d      = we_q ? 32'd0 : ld_data;
            end else if (cnt_inc == TIMEOUT_VAL) begin
               state_d    = S_DONE;
               wb_valid_d = !kill;
               bus_err_d  = !kill;
               wb_rd_d    = rd_q;
               cnt_d      = cnt_inc;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         S_DONE: begin
            // The finished instruction still sits in the MEM register this
            // cycle, so the inputs are ignored.
            state_d      = S_IDLE;
            flush_pend_d = 1'b0;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= 8'd0;
         flush_pend_q   <= 1'b0;
         addr_q         <= 32'd0;
         funct3_q       <= 3'd0;
         we_q           <= 1'b0;
         wstrb_q        <= 4'd0;
         wdata_q        <= 32'd0;
         rd_q           <= 5'd0;
         reg_write_q    <= 1'b0;
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_rd_q        <= 5'd0;
         wb_data_q      <= 32'd0;
         misalign_q     <= 1'b0;
         bus_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         flush_pend_q   <= flush_pend_d;
         addr_q         <= addr_d;
         funct3_q       <= funct3_d;
         we_q           <= we_d;
         wstrb_q        <= wstrb_d;
         wdata_q        <= wdata_d;
         rd_q           <= rd_d;
         reg_write_q    <= reg_write_d;
         wb_valid_q     <= wb_valid_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_rd_q        <= wb_rd_d;
         wb_data_q      <= wb_data_d;
         misalign_q     <= misalign_d;
         bus_err_q      <= bus_err_d;
      end
   end

   // The request is live only in WAIT, so leaving WAIT (ack, timeout or
   // reset) withdraws it on the next cycle.
   assign dmem_req     = (state_q == S_WAIT);
   assign dmem_we      = dmem_req & we_q;
   assign dmem_wstrb   = dmem_req ? wstrb_q : 4'b0000;
   assign dmem_addr    = {addr_q[31:2], 2'b00};
   assign dmem_wdata   = wdata_q;

   assign wb_valid     = wb_valid_q;
   assign wb_reg_write = wb_reg_write_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign misalign_exc = misalign_q;
   assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. The expected writeback is queued when
// the instruction is driven. A negedge monitor pops the queue whenever
// wb_valid is seen and compares the popped entry with the outputs.
// Bus-side behaviour is checked at fixed cycles in the main sequence.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_mem_read = 1'b0;
   logic        in_mem_write = 1'b0;
   logic [2:0]  in_funct3 = 3'd0;
   logic [31:0] in_addr = 32'd0;
   logic [31:0] in_wdata = 32'd0;
   logic [31:0] in_alu = 32'd0;
   logic [4:0]  in_rd = 5'd0;
   logic        in_reg_write = 1'b0;
   logic        flush = 1'b0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        stall, wb_valid, wb_reg_write, misalign_exc, bus_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   typedef struct {
      logic [4:0]  rd;
      logic        reg_write;
      logic        chk_data;
      logic [31:0] data;
      logic        misalign;
      logic        bus_err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_alu(in_alu),
      .in_rd(in_rd), .in_reg_write(in_reg_write), .flush(flush),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .wb_data(wb_data), .misalign_exc(misalign_exc), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] alu, input logic [4:0] rd, input logic rw);
      in_valid     = 1'b1;
      in_mem_read  = rd_en;
      in_mem_write = wr_en;
      in_funct3    = f3;
      in_addr      = addr;
      in_wdata     = wd;
      in_alu       = alu;
      in_rd        = rd;
      in_reg_write = rw;
   endtask

   task automatic bubble();
      in_valid     = 1'b0;
      in_mem_read  = 1'b0;
      in_mem_write = 1'b0;
   endtask

   task automatic push(input logic [4:0] rd, input logic rw, input logic cd,
                       input logic [31:0] d, input logic mis, input logic be);
      exp_t e;
      e.rd = rd; e.reg_write = rw; e.chk_data = cd; e.data = d;
      e.misalign = mis; e.bus_err = be;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!reset) begin
         if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
               check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, mon_e.reg_write});
               check("wb_misalign", {31'd0, misalign_exc}, {31'd0, mon_e.misalign});
               check("wb_bus_err", {31'd0, bus_err}, {31'd0, mon_e.bus_err});
               if (mon_e.chk_data) check("wb_data", wb_data, mon_e.data);
            end
         end else begin
            check("exc_without_wb", {30'd0, misalign_exc, bus_err}, 32'd0);
         end
      end
   end

   initial begin
      // Reset state.
      tick(); tick();
      mid();
      check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
      check("rst_dmem_wstrb", {28'd0, dmem_wstrb}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
      tick();
      reset = 1'b0;

      // ALU op: writeback one cycle later, no stall.
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1);
      push(5'd5, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      mid(); check("alu_stall", {31'd0, stall}, 32'd0);
      tick(); bubble();
      mid(); check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
      tick();

      // LB 0x1003, ack two cycles after issue -> 0xFFFFFF80 at T+3.
      drive(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h0, 5'd7, 1'b1);
      push(5'd7, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
      mid(); check("lb_stall_t0", {31'd0, stall}, 32'd1);
      tick();
      mid(); check("lb_req_t1", {31'd0, dmem_req}, 32'd1);
      check("lb_addr_t1", dmem_addr, 32'h0000_1000);
      check("lb_we_t1", {31'd0, dmem_we}, 32'd0);
      check("lb_stall_t1", {31'd0, stall}, 32'd1);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF00;
      mid(); check("lb_stall_t2", {31'd0, stall}, 32'd1);
      tick();
      dmem_ack = 1'b0;
      mid(); check("lb_wb_valid_t3", {31'd0, wb_valid}, 32'd1);
      check("lb_stall_t3", {31'd0, stall}, 32'd0);
      check("lb_req_drop_t3", {31'd0, dmem_req}, 32'd0);
      tick(); bubble();
      tick();

      // LH 0x6002, ack on the first WAIT cycle -> sign-extended upper half.
      drive(1'b1, 1'b0, 3'b001, 32'h6002, 32'h0, 32'h0, 5'd12, 1'b1);
      push(5'd12, 1'b1, 1'b1, 32'hFFFF_8001, 1'b0, 1'b0);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'h8001_1234;
      tick();
      dmem_ack = 1'b0;
      mid(); check("lh_wb_valid_t2", {31'd0, wb_valid}, 32'd1);
      tick(); bubble();
      tick();

      // SH 0x2002, data 0xBEEF.
      drive(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h0, 5'd3, 1'b1);
      push(5'd3, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      mid(); check("sh_req", {31'd0, dmem_req}, 32'd1);
      check("sh_we", {31'd0, dmem_we}, 32'd1);
      check("sh_wstrb", {28'd0, dmem_wstrb}, 32'h0000_000C);
      check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
      check("sh_addr", dmem_addr, 32'h0000_2000);
      tick();
      dmem_ack = 1'b1;
      mid(); check("sh_wstrb_held", {28'd0, dmem_wstrb}, 32'h0000_000C);
      tick();
      dmem_ack = 1'b0;
      mid(); check("sh_req_drop", {31'd0, dmem_req}, 32'd0);
      tick(); bubble();
      tick();

      // LW 0x3001: misaligned, no bus, no stall.
      drive(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 5'd4, 1'b1);
      push(5'd4, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      mid(); check("mis_stall", {31'd0, stall}, 32'd0);
      check("mis_req_t0", {31'd0, dmem_req}, 32'd0);
      tick(); bubble();
      mid(); check("mis_req_t1", {31'd0, dmem_req}, 32'd0);
      check("mis_exc", {31'd0, misalign_exc}, 32'd1);
      tick();

      // LW with no ack: four request cycles, then a bus_err pulse.
      drive(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h0, 5'd9, 1'b1);
      push(5'd9, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      for (int i = 0; i < int'(TMO); i++) begin
         mid(); check("tmo_req_high", {31'd0, dmem_req}, 32'd1);
         tick();
      end
      mid(); check("tmo_req_low", {31'd0, dmem_req}, 32'd0);
      check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
      check("tmo_stall", {31'd0, stall}, 32'd0);
      tick(); bubble();
      mid(); check("tmo_bus_err_pulse", {31'd0, bus_err}, 32'd0);
      tick();

      // Ack on the last allowed cycle beats the timeout.
      drive(1'b1, 1'b0, 3'b010, 32'h4004, 32'h0, 32'h0, 5'd8, 1'b1);
      push(5'd8, 1'b1, 1'b1, 32'h1122_3344, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < int'(TMO) - 1; i++) tick();
      dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
      tick();
      dmem_ack = 1'b0;
      mid(); check("race_bus_err", {31'd0, bus_err}, 32'd0);
      tick(); bubble();
      tick();

      // LHU 0x4002 flushed during WAIT, then an ALU op.
      drive(1'b1, 1'b0, 3'b101, 32'h4002, 32'h0, 32'h0, 5'd10, 1'b1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      mid(); check("flush_req_kept", {31'd0, dmem_req}, 32'd1);
      dmem_ack = 1'b1; dmem_rdata = 32'hABCD_0000;
      tick();
      dmem_ack = 1'b0;
      mid(); check("flush_wb_valid", {31'd0, wb_valid}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0055, 5'd11, 1'b1);
      push(5'd11, 1'b1, 1'b1, 32'h0000_0055, 1'b0, 1'b0);
      tick(); bubble();
      mid(); check("post_flush_alu", wb_data, 32'h0000_0055);
      tick();

      // Flush in IDLE discards the instruction.
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0077, 5'd13, 1'b1);
      flush = 1'b1;
      tick(); bubble(); flush = 1'b0;
      mid(); check("idle_flush_wb", {31'd0, wb_valid}, 32'd0);
      tick();

      // Reset during WAIT, late ack ignored.
      drive(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 32'h0, 5'd14, 1'b1);
      tick();
      mid(); check("rstw_req", {31'd0, dmem_req}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0; bubble();
      dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      mid(); check("rstw_req_low", {31'd0, dmem_req}, 32'd0);
      check("rstw_stall", {31'd0, stall}, 32'd0);
      check("rstw_wb_data", wb_data, 32'd0);
      check("rstw_wstrb", {28'd0, dmem_wstrb}, 32'd0);
      tick();
      dmem_ack = 1'b0;
      mid(); check("rstw_no_wb", {31'd0, wb_valid}, 32'd0);
      check("rstw_req_still_low", {31'd0, dmem_req}, 32'd0);
      tick(); tick();

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles to wait for dmem_ack before bus error (1..255).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  MEM pipeline register holds a live instruction.
REQ-005 in_mem_read / in_mem_write  in  1 each  load / store (never both high).
REQ-006 in_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
REQ-007 in_addr  in  32  effective address; in_wdata  in  32  store data; in_alu  in  32  non-memory result.
REQ-008 in_rd  in  5  destination register; in_reg_write  in  1  writeback enable.
REQ-009 flush  in  1  kill the current instruction.
REQ-010 dmem_req  out  1;  dmem_we  out  1;  dmem_addr  out  32 (bits[1:0]=0);  dmem_wstrb  out  4;  dmem_wdata  out  32.
REQ-011 dmem_ack  in  1;  dmem_rdata  in  32  valid when dmem_ack=1.
REQ-012 stall  out  1  to hazard unit; when high, the MEM pipeline register's ld is held low.
REQ-013 wb_valid, wb_reg_write  out  1;  wb_rd  out  5;  wb_data  out  32;  misalign_exc, bus_err  out  1.

Function
REQ-014 FSM states IDLE, WAIT, DONE; all wb_* and exception outputs registered.
REQ-015 IDLE, in_valid=1, no memory op: next cycle wb_valid=1, wb_data=in_alu, wb_rd=in_rd, wb_reg_write=in_reg_write; stall=0.
REQ-016 IDLE, in_valid=1, memory op, aligned (LW: addr[1:0]=0; LH/LHU/SH: addr[0]=0): stall=1 combinationally this cycle; next state WAIT.
REQ-017 Misaligned access: no dmem_req; next cycle wb_valid=1, misalign_exc=1, wb_reg_write=0; stall=0.
REQ-018 WAIT: dmem_req=1, dmem_addr={in_addr[31:2],2'b00}, dmem_we=in_mem_write, stall=1; request fields held constant until ack.
REQ-019 Store strobes: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; dmem_wdata = byte/half replicated across lanes.
REQ-020 WAIT with dmem_ack=1: capture data, go to DONE; dmem_req drops the following cycle.
REQ-021 Load extraction: select byte/half by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-022 DONE (one cycle): wb_valid=1, wb_data=loaded value (stores: wb_reg_write=0), stall=0; return to IDLE.
REQ-023 Latency: load/store issued in cycle T with ack in cycle T+k (k>=1) yields wb_valid in cycle T+k+1.
REQ-024 8-bit wait counter clears on WAIT entry, increments each WAIT cycle without ack; reaching TIMEOUT_CYCLES: drop dmem_req, go to DONE with bus_err=1, wb_reg_write=0.
REQ-025 Ack and timeout in the same cycle: ack wins, no bus_err.
REQ-026 flush in IDLE: instruction discarded, wb_valid=0 next cycle.
REQ-027 flush in WAIT: bus transaction completes normally (request not withdrawn); result discarded, DONE emits wb_valid=0.
REQ-028 wb_valid, misalign_exc and bus_err are single-cycle pulses per instruction.
REQ-029 dmem_ack outside WAIT is ignored.

Reset
REQ-030 reset forces IDLE, counter 0, flush-pending 0, dmem_req=0, dmem_we=0, dmem_wstrb=0, stall=0, wb_valid=0, wb_reg_write=0, wb_rd=0, wb_data=0, misalign_exc=0, bus_err=0.
REQ-031 reset mid-WAIT abandons the transaction: dmem_req low the next cycle; no wb_valid produced.

Verification
REQ-032 LB at addr 0x1003, rdata 0x80FF_FF00, ack after 2 cycles -> wb_data=0xFFFF_FF80, wb_valid at T+3, stall high for 3 cycles.
REQ-033 SH at 0x2002, wdata 0x0000_BEEF -> wstrb=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, wb_reg_write=0.
REQ-034 LW at 0x3001 -> no dmem_req, misalign_exc=1 next cycle, stall never asserted.
REQ-035 LW with ack never returned, TIMEOUT_CYCLES=4 -> dmem_req high 4 cycles, then bus_err=1 pulse, back to IDLE.
REQ-036 LHU at 0x4002, flush during WAIT, ack rdata 0xABCD_0000 -> no wb_valid; next ALU op (in_alu=0x55) -> wb_data=0x55 one cycle later.
REQ-037 reset asserted during WAIT -> all outputs at reset values next cycle; late dmem_ack ignored.
